// File: rtl/test_pattern_gen.sv
// test_pattern_gen: serialises one of NPAT programmable W-bit patterns onto s_out,
// LSB- or MSB-first, single-shot or looping, with abort and a runtime write port.
module test_pattern_gen #(
    parameter int                W        = 8,
    parameter int                NPAT     = 4,
    parameter int                SELW     = 2,
    parameter logic [NPAT*W-1:0] PAT_INIT = {8'h01, 8'hF0, 8'h3C, 8'hA5}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [SELW-1:0] sel,
    input  logic            msb_first,
    input  logic            loop,
    input  logic            wr_en,
    input  logic [SELW-1:0] wr_addr,
    input  logic [W-1:0]    wr_data,
    output logic            s_out,
    output logic            s_valid,
    output logic            last,
    output logic            busy,
    output logic            seq_d
);
    localparam int KW = $clog2(W);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t          state, nxt_state;
    logic [KW-1:0]   k, nxt_k, idx;
    logic [W-1:0]    pat, nxt_pat;
    logic [W-1:0]    mem [NPAT];
    logic [SELW-1:0] sel_q, nxt_sel, sel_eff;
    logic            msb_q, nxt_msb, loop_q, nxt_loop;
    logic            go, wrap, run_n;
    logic            nxt_s_out, nxt_last, nxt_seq_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            k       <= '0;
            pat     <= '0;
            sel_q   <= '0;
            msb_q   <= 1'b0;
            loop_q  <= 1'b0;
            s_out   <= 1'b0;
            s_valid <= 1'b0;
            last    <= 1'b0;
            busy    <= 1'b0;
            seq_d   <= 1'b0;
            for (int i = 0; i < NPAT; i++) mem[i] <= PAT_INIT[i*W +: W];
        end else begin
            state   <= nxt_state;
            k       <= nxt_k;
            pat     <= nxt_pat;
            sel_q   <= nxt_sel;
            msb_q   <= nxt_msb;
            loop_q  <= nxt_loop;
            s_out   <= nxt_s_out;
            s_valid <= run_n;
            last    <= nxt_last;
            busy    <= run_n;
            seq_d   <= nxt_seq_d;
            if (wr_en && 32'(wr_addr) < NPAT) mem[wr_addr] <= wr_data;
        end
    end

    // pat is a snapshot so writes to the active entry only land on the next pass
    always_comb begin
        go        = state != RUN && start && !abort;
        wrap      = state == RUN && k == KW'(W-1);
        sel_eff   = (32'(sel) < NPAT) ? sel : '0;
        nxt_state = state;
        nxt_k     = k;
        nxt_pat   = pat;
        nxt_sel   = sel_q;
        nxt_msb   = msb_q;
        nxt_loop  = loop_q;
        if (abort) begin
            nxt_state = IDLE;
        end else if (go) begin
            nxt_state = RUN;
            nxt_k     = '0;
            nxt_pat   = mem[sel_eff];
            nxt_sel   = sel_eff;
            nxt_msb   = msb_first;
            nxt_loop  = loop;
        end else if (state == RUN) begin
            nxt_k     = wrap ? '0 : k + 1'b1;
            nxt_state = (wrap && !loop_q) ? DONE : RUN;
            nxt_pat   = (wrap && loop_q) ? mem[sel_q] : pat;
        end
    end

    // outputs are registered, so they are derived from the next-state values
    always_comb begin
        run_n     = nxt_state == RUN;
        idx       = nxt_msb ? KW'(W-1) - nxt_k : nxt_k;
        nxt_s_out = run_n & nxt_pat[idx];
        nxt_last  = run_n && nxt_k == KW'(W-1);
        nxt_seq_d = (abort || go) ? 1'b0 : (wrap && !loop_q) ? 1'b1 : seq_d;
    end
endmodule
